// File: rtl/draw_pkg.sv
// Shared definitions for the frame draw sequencer: command codes, FSM states,
// sprite-kind codes and the empty-slot skip helper.
package draw_pkg;

  // Commands understood by the pixel Processor
  localparam logic [4:0] CMD_NOTE1  = 5'b00010;
  localparam logic [4:0] CMD_DIGIT1 = 5'b10001;
  localparam logic [4:0] CMD_DIGIT2 = 5'b10010;
  localparam logic [4:0] CMD_CLEAR  = 5'b10100;
  localparam logic [4:0] CMD_COMMIT = 5'b10101;
  localparam logic [4:0] CMD_NOP    = 5'b10110;
  localparam logic [4:0] CMD_COMBO1 = 5'b10111;

  // Sprite kinds, same coding as the Processor colour inputs
  localparam logic [2:0] KIND_NOTE   = 3'b000;
  localparam logic [2:0] KIND_RED_S  = 3'b001;
  localparam logic [2:0] KIND_BLUE_S = 3'b010;
  localparam logic [2:0] KIND_RED_B  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_NOTE,
    ST_DIGIT,
    ST_COMBO,
    ST_COMMIT
  } state_t;

  // First occupied slot numbered from 'from' upward; 16 means none left
  function automatic logic [4:0] first_valid_slot(input logic [4:0] from,
                                                  input logic [14:0] valid);
    logic [4:0] r;
    r = 5'd16;
    for (int i = 15; i >= 1; i--) begin
      if (5'(i) >= from && valid[i-1]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-command dwell counter: counts 0..len-1 and flags the last cycle.
module dwell_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] len,
  input  logic        en,
  output logic        tc
);

  logic [11:0] count;
  logic [11:0] limit;

  // Load restarts the count for a new phase; otherwise step while enabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 12'd0;
      limit <= 12'd1;
    end else if (load) begin
      count <= 12'd0;
      limit <= len;
    end else if (en) begin
      count <= tc ? 12'd0 : count + 12'd1;
    end
  end

  assign tc = (count == limit - 12'd1);

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level draw scheduler: steps the Processor command through clear,
// 15 note slots, 2 score digits, 3 combo bars and a one-cycle commit.
// Build option DRAW_SKIP_EMPTY_EN: unoccupied note slots take zero cycles.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned CLEAR_PIX = 2268,
  parameter int unsigned NOTE_PIX  = 16,
  parameter int unsigned SMALL_PIX = 81,
  parameter int unsigned BIG_PIX   = 169,
  parameter int unsigned DIGIT_PIX = 35,
  parameter int unsigned COMBO_PIX = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [29:0] slot_kind,
  input  logic [14:0] slot_valid,
  output logic [4:0]  command,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  state_t      state;
  logic [3:0]  idx;
  logic [4:0]  cmd_q;
  state_t      nstate;
  logic [3:0]  nidx;
  logic [4:0]  ncmd;
  logic [11:0] nlen;
  logic [4:0]  from_slot;
  logic [4:0]  target;
  logic [2:0]  kind;
  logic        tc;
  logic        accept;
  logic        advance;
  logic        cnt_load;
  logic [11:0] cnt_len;

  function automatic logic [11:0] kind_dwell(input logic [2:0] k);
    if (k == KIND_NOTE) return 12'(NOTE_PIX);
    if (k == KIND_RED_S || k == KIND_BLUE_S) return 12'(SMALL_PIX);
    return 12'(BIG_PIX);
  endfunction

`ifndef DRAW_SKIP_EMPTY_EN
  logic unused_valid;
  assign unused_valid = ^slot_valid;
`endif

  // Next note slot to visit, optionally jumping over empty ones
  always_comb begin
    from_slot = (state == ST_NOTE) ? {1'b0, idx} + 5'd1 : 5'd1;
`ifdef DRAW_SKIP_EMPTY_EN
    target = first_valid_slot(from_slot, slot_valid);
`else
    target = from_slot;
`endif
  end

  // Sprite kind of the slot about to be entered, sampled at the entry decision
  always_comb begin
    kind = KIND_NOTE;
    for (int i = 0; i < 10; i++) begin
      if (target == 5'(i + 1)) kind = slot_kind[3*i +: 3];
    end
  end

  // Phase that follows the current one, with its command and dwell length
  always_comb begin
    nstate = ST_IDLE;
    nidx   = 4'd0;
    ncmd   = CMD_NOP;
    nlen   = 12'd1;
    case (state)
      ST_CLEAR, ST_NOTE: begin
        if (target <= 5'd15) begin
          nstate = ST_NOTE;
          nidx   = target[3:0];
          ncmd   = target + 5'd1;
          nlen   = (target <= 5'd10) ? kind_dwell(kind) : 12'(NOTE_PIX);
        end else begin
          nstate = ST_DIGIT;
          nidx   = 4'd1;
          ncmd   = CMD_DIGIT1;
          nlen   = 12'(DIGIT_PIX);
        end
      end
      ST_DIGIT: begin
        if (idx == 4'd1) begin
          nstate = ST_DIGIT;
          nidx   = 4'd2;
          ncmd   = CMD_DIGIT2;
          nlen   = 12'(DIGIT_PIX);
        end else begin
          nstate = ST_COMBO;
          nidx   = 4'd1;
          ncmd   = CMD_COMBO1;
          nlen   = 12'(COMBO_PIX);
        end
      end
      ST_COMBO: begin
        if (idx < 4'd3) begin
          nstate = ST_COMBO;
          nidx   = idx + 4'd1;
          ncmd   = CMD_COMBO1 + {1'b0, idx};
          nlen   = 12'(COMBO_PIX);
        end else begin
          nstate = ST_COMMIT;
          nidx   = 4'd0;
          ncmd   = CMD_COMMIT;
          nlen   = 12'd1;
        end
      end
      default: begin
        nstate = ST_IDLE;
      end
    endcase
  end

  assign accept   = (state == ST_IDLE) && start && enable;
  assign advance  = (state != ST_IDLE) && enable && tc;
  assign cnt_load = accept || advance;
  assign cnt_len  = accept ? 12'(CLEAR_PIX) : nlen;

  dwell_counter u_dwell (
    .clk   (CLK),
    .reset (reset),
    .load  (cnt_load),
    .len   (cnt_len),
    .en    (busy && enable),
    .tc    (tc)
  );

  // Sequencing FSM with registered command, busy, done and overrun flags
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      cmd_q      <= CMD_NOP;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          state   <= ST_CLEAR;
          idx     <= 4'd0;
          cmd_q   <= CMD_CLEAR;
          busy    <= 1'b1;
          overrun <= 1'b0;
        end
      end else begin
        if (start) overrun <= 1'b1;
        if (advance) begin
          state <= nstate;
          idx   <= nidx;
          cmd_q <= ncmd;
          if (nstate == ST_IDLE) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

  // A paused frame shows no-op while the counter and state stay frozen
  assign command = (busy && !enable) ? CMD_NOP : cmd_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed testbench for draw_sequencer: frame timing, sprite dwell,
// pause/resume, overrun handling and the DRAW_SKIP_EMPTY_EN build option.
module tb_draw_sequencer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [29:0] slot_kind;
  logic [14:0] slot_valid;
  logic [4:0]  command;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int fails  = 0;

  logic [4:0] run_cmd[$];
  int         run_len[$];
  logic [4:0] exp_cmd[$];
  int         exp_len[$];
  int         done_cycle;
  int         ov_cycle;
  logic       ov_at_done;
  logic       busy_dropped;

  draw_sequencer dut (
    .CLK        (CLK),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .slot_kind  (slot_kind),
    .slot_valid (slot_valid),
    .command    (command),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  // 50 MHz clock
  always #10 CLK = ~CLK;

  task automatic reset_dut;
    reset = 1'b0;
    start = 1'b0;
    enable = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1 reset = 1'b1;
  endtask

  task automatic push(input logic [4:0] c, input int n);
    exp_cmd.push_back(c);
    exp_len.push_back(n);
  endtask

  // Expected runs from plain note slot 'from' (16 cycles each) to the commit
  task automatic push_tail(input int from);
    for (int n = from; n <= 15; n++) push(5'(n + 1), 16);
    push(5'b10001, 35);
    push(5'b10010, 35);
    push(5'b10111, 16);
    push(5'b11000, 16);
    push(5'b11001, 16);
    push(5'b10101, 1);
  endtask

  // Pulse start, then record run-lengths of command until frame_done
  task automatic capture_frame(input int pause_at, input int pause_len, input int restart_at);
    logic [4:0] cur;
    int cur_len;
    run_cmd.delete();
    run_len.delete();
    done_cycle = -1;
    ov_cycle = -1;
    ov_at_done = 1'b0;
    busy_dropped = 1'b0;
    cur = 5'h1f;
    cur_len = 0;
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      enable = !(k >= pause_at && k < pause_at + pause_len);
      start = (k == restart_at);
      @(negedge CLK);
      if (frame_done) begin
        done_cycle = k;
        ov_at_done = overrun;
        break;
      end
      if (!busy) busy_dropped = 1'b1;
      if (overrun && ov_cycle < 0) ov_cycle = k;
      if (cur_len > 0 && command == cur) begin
        cur_len++;
      end else begin
        if (cur_len > 0) begin
          run_cmd.push_back(cur);
          run_len.push_back(cur_len);
        end
        cur = command;
        cur_len = 1;
      end
      @(posedge CLK); #1;
    end
    if (cur_len > 0) begin
      run_cmd.push_back(cur);
      run_len.push_back(cur_len);
    end
    start = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    slot_kind = '0;
    slot_valid = '1;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b1;
    @(negedge CLK);
    checks++;
    if ({command, busy, frame_done, overrun} !== {5'b10110, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset_state: got cmd=%b busy=%b done=%b ovr=%b, expected 10110 0 0 0",
               command, busy, frame_done, overrun);
    end
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (49) @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (49) @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if ({command, busy, overrun} !== {5'b10100, 2'b11}) begin
      fails++;
      $display("[TB] FAIL mid_clear: got cmd=%b busy=%b ovr=%b, expected 10100 1 1",
               command, busy, overrun);
    end
    reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({command, busy, frame_done, overrun} !== {5'b10110, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset_abort: got cmd=%b busy=%b done=%b ovr=%b, expected 10110 0 0 0",
               command, busy, frame_done, overrun);
    end
    repeat (4) @(posedge CLK);
    #1 reset = 1'b1;
    enable = 1'b0;
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    enable = 1'b1;
    @(negedge CLK);
    checks++;
    if ({command, busy} !== {5'b10110, 1'b0}) begin
      fails++;
      $display("[TB] FAIL start_disabled: got cmd=%b busy=%b, expected 10110 0", command, busy);
    end
  endtask

  task automatic test_full_frame;
    reset_dut();
    slot_kind = '0;
    slot_valid = '1;
    exp_cmd.delete();
    exp_len.delete();
    push(5'b10100, 2268);
    push_tail(1);
    capture_frame(0, 0, 0);
    checks++;
    if (run_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("[TB] FAIL full_runs: got %0d runs, expected %0d", run_cmd.size(), exp_cmd.size());
    end
    for (int i = 0; i < exp_cmd.size() && i < run_cmd.size(); i++) begin
      checks++;
      if (run_cmd[i] !== exp_cmd[i] || run_len[i] != exp_len[i]) begin
        fails++;
        $display("[TB] FAIL full_run%0d: got %b x%0d, expected %b x%0d",
                 i, run_cmd[i], run_len[i], exp_cmd[i], exp_len[i]);
      end
    end
    checks++;
    if (done_cycle != 2628) begin
      fails++;
      $display("[TB] FAIL full_done: got cycle %0d, expected 2628", done_cycle);
    end
    checks++;
    if (busy_dropped !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_busy: got dropped=%b busy_at_done=%b, expected 0 0", busy_dropped, busy);
    end
  endtask

  task automatic test_sprite_kinds;
    reset_dut();
    slot_kind = {24'b0, 3'b011, 3'b001};
    slot_valid = '1;
    exp_cmd.delete();
    exp_len.delete();
    push(5'b10100, 2268);
    push(5'b00010, 81);
    push(5'b00011, 169);
    push_tail(3);
    capture_frame(0, 0, 0);
    checks++;
    if (run_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("[TB] FAIL kind_runs: got %0d runs, expected %0d", run_cmd.size(), exp_cmd.size());
    end
    for (int i = 0; i < exp_cmd.size() && i < run_cmd.size(); i++) begin
      checks++;
      if (run_cmd[i] !== exp_cmd[i] || run_len[i] != exp_len[i]) begin
        fails++;
        $display("[TB] FAIL kind_run%0d: got %b x%0d, expected %b x%0d",
                 i, run_cmd[i], run_len[i], exp_cmd[i], exp_len[i]);
      end
    end
    checks++;
    if (done_cycle != 2846) begin
      fails++;
      $display("[TB] FAIL kind_done: got cycle %0d, expected 2846", done_cycle);
    end
  endtask

  task automatic test_pause;
    reset_dut();
    slot_kind = '0;
    slot_valid = '1;
    exp_cmd.delete();
    exp_len.delete();
    push(5'b10100, 2268);
    push(5'b00010, 16);
    push(5'b00011, 16);
    push(5'b00100, 5);
    push(5'b10110, 10);
    push(5'b00100, 11);
    push_tail(4);
    capture_frame(2306, 10, 0);
    checks++;
    if (run_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("[TB] FAIL pause_runs: got %0d runs, expected %0d", run_cmd.size(), exp_cmd.size());
    end
    for (int i = 0; i < exp_cmd.size() && i < run_cmd.size(); i++) begin
      checks++;
      if (run_cmd[i] !== exp_cmd[i] || run_len[i] != exp_len[i]) begin
        fails++;
        $display("[TB] FAIL pause_run%0d: got %b x%0d, expected %b x%0d",
                 i, run_cmd[i], run_len[i], exp_cmd[i], exp_len[i]);
      end
    end
    checks++;
    if (done_cycle != 2638 || busy_dropped !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pause_done: got cycle %0d dropped=%b, expected 2638 0", done_cycle, busy_dropped);
    end
  endtask

  task automatic test_back_to_back;
    reset_dut();
    slot_kind = '0;
    slot_valid = '1;
    exp_cmd.delete();
    exp_len.delete();
    push(5'b10100, 2268);
    push_tail(1);
    capture_frame(0, 0, 100);
    checks++;
    if (ov_cycle != 101 || ov_at_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overrun_set: got first cycle %0d at_done=%b, expected 101 1", ov_cycle, ov_at_done);
    end
    checks++;
    if (run_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("[TB] FAIL b2b_runs: got %0d runs, expected %0d", run_cmd.size(), exp_cmd.size());
    end
    for (int i = 0; i < exp_cmd.size() && i < run_cmd.size(); i++) begin
      checks++;
      if (run_cmd[i] !== exp_cmd[i] || run_len[i] != exp_len[i]) begin
        fails++;
        $display("[TB] FAIL b2b_run%0d: got %b x%0d, expected %b x%0d",
                 i, run_cmd[i], run_len[i], exp_cmd[i], exp_len[i]);
      end
    end
    checks++;
    if (done_cycle != 2628) begin
      fails++;
      $display("[TB] FAIL b2b_done: got cycle %0d, expected 2628", done_cycle);
    end
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(negedge CLK);
    checks++;
    if ({command, busy, overrun} !== {5'b10100, 2'b10}) begin
      fails++;
      $display("[TB] FAIL restart_on_done: got cmd=%b busy=%b ovr=%b, expected 10100 1 0",
               command, busy, overrun);
    end
  endtask

  task automatic test_skip_empty;
    int exp_done;
    reset_dut();
    slot_kind = '0;
    slot_valid = 15'h0001;
    exp_cmd.delete();
    exp_len.delete();
    push(5'b10100, 2268);
`ifdef DRAW_SKIP_EMPTY_EN
    push(5'b00010, 16);
    push_tail(16);
    exp_done = 2404;
`else
    push_tail(1);
    exp_done = 2628;
`endif
    capture_frame(0, 0, 0);
    checks++;
    if (run_cmd.size() != exp_cmd.size()) begin
      fails++;
      $display("[TB] FAIL skip_runs: got %0d runs, expected %0d", run_cmd.size(), exp_cmd.size());
    end
    for (int i = 0; i < exp_cmd.size() && i < run_cmd.size(); i++) begin
      checks++;
      if (run_cmd[i] !== exp_cmd[i] || run_len[i] != exp_len[i]) begin
        fails++;
        $display("[TB] FAIL skip_run%0d: got %b x%0d, expected %b x%0d",
                 i, run_cmd[i], run_len[i], exp_cmd[i], exp_len[i]);
      end
    end
    checks++;
    if (done_cycle != exp_done) begin
      fails++;
      $display("[TB] FAIL skip_done: got cycle %0d, expected %0d", done_cycle, exp_done);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sprite_kinds();
    test_pause();
    test_back_to_back();
    test_skip_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
